// File: rtl/keyboard_cmd_sender_if.sv
// keyboard_cmd_sender_if
//   Byte-level link between keyboard_cmd_sender and the ps2_host block.
//   master: the command sender (drives tx_data/tx_valid, receives responses).
//   slave : the ps2_host side (accepts transmit bytes, delivers received bytes).
//   Signals:
//     tx_data  [7:0] byte to transmit to the keyboard
//     tx_valid       tx_data is valid, held until tx_ready
//     tx_ready       ps2_host accepts tx_data this cycle
//     rx_data  [7:0] byte received from the keyboard
//     rx_ready       rx_data valid for this cycle only
interface keyboard_cmd_sender_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready,
                  input rx_data, input rx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready,
                  output rx_data, output rx_ready);
endinterface

// File: rtl/keyboard_cmd_sender.sv
// keyboard_cmd_sender
//   Host-to-keyboard command sequencer. Turns keyboard-reset and set-LED
//   requests into PS/2 command bytes, checks the keyboard's ACK / RESEND /
//   BAT responses, retries on RESEND or response timeout, and reports
//   completion (done) or failure (error + err_code) to the game logic.
//   Optional build macro: KBD_CMD_AUTO_INIT_EN -- when defined, the first
//   cycle after reset release acts as a simultaneous req_reset + req_leds(000).
//   Ports:
//     clk, reset (async, active low)
//     req_reset, req_leds, leds[2:0]  request pulses and LED value
//     ps2 (master modport)            tx/rx byte link to ps2_host
//     busy                            not idle
//     done, error                     one-cycle completion / failure pulses
//     err_code[1:0]                   01 no ACK, 10 BAT fail, 11 BAT timeout
//     leds_state[2:0]                 last LED value acknowledged
module keyboard_cmd_sender #(
  parameter int unsigned TIMEOUT_CYCLES     = 32'd2_500_000,
  parameter int unsigned BAT_TIMEOUT_CYCLES = 32'd50_000_000,
  parameter int unsigned MAX_RETRIES        = 32'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_reset,
  input  logic       req_leds,
  input  logic [2:0] leds,
  keyboard_cmd_sender_if.master ps2,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [2:0] leds_state
);

  localparam int unsigned CNT_MAX = (BAT_TIMEOUT_CYCLES > TIMEOUT_CYCLES) ?
                                    BAT_TIMEOUT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 32'd1);
  localparam int RW = $clog2(MAX_RETRIES + 32'd2);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND_CMD  = 3'd1;
  localparam logic [2:0] S_WAIT_ACK1 = 3'd2;
  localparam logic [2:0] S_SEND_ARG  = 3'd3;
  localparam logic [2:0] S_WAIT_ACK2 = 3'd4;
  localparam logic [2:0] S_WAIT_BAT  = 3'd5;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_LEDS     = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  logic [2:0]    state_q, state_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [2:0]    arg_q, arg_d;
  logic          pend_q, pend_d;
  logic [2:0]    pend_leds_q, pend_leds_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [2:0]    leds_state_q, leds_state_d;

  logic          eff_req_reset_s;
  logic          eff_req_leds_s;
  logic [2:0]    eff_leds_s;
  logic          ack_s, resend_s, timeout_s, bat_timeout_s;

`ifdef KBD_CMD_AUTO_INIT_EN
  logic init_q, init_d;
  assign init_d = 1'b0;

  // One-shot flag that is set by reset and injects the power-up requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) init_q <= 1'b1;
    else        init_q <= init_d;
  end

  assign eff_req_reset_s = req_reset | init_q;
  assign eff_req_leds_s  = req_leds | init_q;
  assign eff_leds_s      = init_q ? 3'b000 : leds;
`else
  assign eff_req_reset_s = req_reset;
  assign eff_req_leds_s  = req_leds;
  assign eff_leds_s      = leds;
`endif

  assign ack_s         = ps2.rx_ready && (ps2.rx_data == RSP_ACK);
  assign resend_s      = ps2.rx_ready && (ps2.rx_data == RSP_RESEND);
  assign timeout_s     = (cnt_q == CW'(TIMEOUT_CYCLES - 32'd1));
  assign bat_timeout_s = (cnt_q == CW'(BAT_TIMEOUT_CYCLES - 32'd1));

  // Next-state and output computation for the command sequencer.
  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    arg_d        = arg_q;
    pend_d       = pend_q;
    pend_leds_d  = pend_leds_q;
    retry_d      = retry_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    err_code_d   = err_code_q;
    leds_state_d = leds_state_q;

    // LED requests arriving while busy are parked; the latest one wins.
    if (state_q != S_IDLE && eff_req_leds_s) begin
      pend_d      = 1'b1;
      pend_leds_d = eff_leds_s;
    end else begin
      pend_d      = pend_q;
    end

    case (state_q)
      S_IDLE: begin
        if (eff_req_reset_s) begin
          state_d    = S_SEND_CMD;
          tx_data_d  = CMD_RESET;
          tx_valid_d = 1'b1;
          retry_d    = {RW{1'b0}};
          err_code_d = 2'b00;
          if (eff_req_leds_s) begin
            pend_d      = 1'b1;
            pend_leds_d = eff_leds_s;
          end else begin
            pend_d      = pend_q;
          end
        end else if (eff_req_leds_s || pend_q) begin
          // A fresh request is newer than anything parked, so it takes precedence.
          state_d    = S_SEND_CMD;
          tx_data_d  = CMD_LEDS;
          tx_valid_d = 1'b1;
          retry_d    = {RW{1'b0}};
          err_code_d = 2'b00;
          arg_d      = eff_req_leds_s ? eff_leds_s : pend_leds_q;
          pend_d     = 1'b0;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_SEND_CMD, S_SEND_ARG: begin
        if (ps2.tx_ready) begin
          tx_valid_d = 1'b0;
          cnt_d      = {CW{1'b0}};
          state_d    = (state_q == S_SEND_CMD) ? S_WAIT_ACK1 : S_WAIT_ACK2;
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      S_WAIT_ACK1, S_WAIT_ACK2: begin
        cnt_d = cnt_q + CW'(1);
        if (ack_s) begin
          if (state_q == S_WAIT_ACK2) begin
            leds_state_d = arg_q;
            done_d       = 1'b1;
            state_d      = S_IDLE;
          end else if (tx_data_q == CMD_LEDS) begin
            state_d    = S_SEND_ARG;
            tx_data_d  = {5'b00000, arg_q};
            tx_valid_d = 1'b1;
            retry_d    = {RW{1'b0}};
          end else begin
            state_d = S_WAIT_BAT;
            cnt_d   = {CW{1'b0}};
          end
        end else if (resend_s || timeout_s) begin
          // Retransmit the byte still held in tx_data_q unless retries are spent.
          if (retry_q == RW'(MAX_RETRIES)) begin
            error_d    = 1'b1;
            err_code_d = 2'b01;
            state_d    = S_IDLE;
          end else begin
            retry_d    = retry_q + RW'(1);
            tx_valid_d = 1'b1;
            state_d    = (state_q == S_WAIT_ACK1) ? S_SEND_CMD : S_SEND_ARG;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_WAIT_BAT: begin
        cnt_d = cnt_q + CW'(1);
        if (ps2.rx_ready && ps2.rx_data == RSP_BAT_OK) begin
          done_d       = 1'b1;
          leds_state_d = 3'b000;
          state_d      = S_IDLE;
        end else if (ps2.rx_ready && ps2.rx_data == RSP_BAT_FAIL) begin
          error_d    = 1'b1;
          err_code_d = 2'b10;
          state_d    = S_IDLE;
        end else if (bat_timeout_s) begin
          error_d    = 1'b1;
          err_code_d = 2'b11;
          state_d    = S_IDLE;
        end else begin
          state_d = S_WAIT_BAT;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      arg_q        <= 3'b000;
      pend_q       <= 1'b0;
      pend_leds_q  <= 3'b000;
      retry_q      <= {RW{1'b0}};
      cnt_q        <= {CW{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 2'b00;
      leds_state_q <= 3'b000;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      arg_q        <= arg_d;
      pend_q       <= pend_d;
      pend_leds_q  <= pend_leds_d;
      retry_q      <= retry_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      leds_state_q <= leds_state_d;
    end
  end

  assign ps2.tx_data  = tx_data_q;
  assign ps2.tx_valid = tx_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign leds_state   = leds_state_q;

endmodule

// File: tb/tb_keyboard_cmd_sender.sv
// tb_keyboard_cmd_sender
//   Self-checking bench for keyboard_cmd_sender. The bench plays the role of
//   ps2_host plus the keyboard: it accepts transmitted bytes (with random
//   back-pressure) and answers with ACK / RESEND / BAT bytes. Transactions
//   come from a hand-written table and from random records whose expected
//   outcome is derived by a transaction-level model.
module tb_keyboard_cmd_sender;
  localparam int unsigned TO  = 100;
  localparam int unsigned BAT = 300;
  localparam int unsigned MR  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_reset, req_leds;
  logic [2:0] leds;
  logic       busy, done, error;
  logic [1:0] err_code;
  logic [2:0] leds_state;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  keyboard_cmd_sender_if ps2 ();

  keyboard_cmd_sender #(
    .TIMEOUT_CYCLES(TO), .BAT_TIMEOUT_CYCLES(BAT), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .reset(reset), .req_reset(req_reset), .req_leds(req_leds),
    .leds(leds), .ps2(ps2), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .leds_state(leds_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One transaction: request kind, keyboard behaviour, expected outcome.
  //   k_cmd/k_arg: number of RESENDs the keyboard answers before ACKing
  //   bat: 0 = 0xAA, 1 = 0xFC, 2 = silence
  typedef struct {
    logic       is_reset;
    logic [2:0] leds;
    int         k_cmd;
    int         k_arg;
    int         bat;
    logic       exp_done;
    logic [1:0] exp_code;
    logic [2:0] exp_ls;
  } txn_t;

  txn_t table_v [11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic rr, input logic rl, input logic [2:0] lv);
    req_reset = rr;
    req_leds  = rl;
    leds      = lv;
    tick();
    req_reset = 1'b0;
    req_leds  = 1'b0;
    leds      = 3'($urandom);
  endtask

  // Wait for a transmit byte, check it and its stability, then accept it.
  task automatic expect_tx(input logic [7:0] b, input string nm,
                           output int first_cyc, output int hs_cyc);
    int n;
    n = 0;
    while (!ps2.tx_valid && n < 500) begin
      tick();
      n++;
    end
    first_cyc = cyc;
    hs_cyc    = cyc;
    check({nm, "_tx_seen"}, 32'(ps2.tx_valid), 32'd1);
    if (!ps2.tx_valid) return;
    check({nm, "_tx_data"}, 32'(ps2.tx_data), 32'(b));
    repeat ($urandom_range(0, 2)) begin
      tick();
      check({nm, "_tx_hold"}, {23'd0, ps2.tx_valid, ps2.tx_data}, {23'd0, 1'b1, b});
    end
    ps2.tx_ready = 1'b1;
    hs_cyc = cyc;
    tick();
    ps2.tx_ready = 1'b0;
    check({nm, "_tx_drop"}, 32'(ps2.tx_valid), 32'd0);
  endtask

  // Keyboard answer after a short random delay, sometimes preceded by junk.
  task automatic reply(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) tick();
    if ($urandom_range(0, 3) == 0) begin
      ps2.rx_data  = 8'h55;
      ps2.rx_ready = 1'b1;
      tick();
    end
    ps2.rx_data  = b;
    ps2.rx_ready = 1'b1;
    tick();
    ps2.rx_ready = 1'b0;
    ps2.rx_data  = 8'($urandom);
  endtask

  task automatic wait_result(input logic ed, input logic [1:0] ec,
                             input logic [2:0] els, input string nm);
    int n;
    n = 0;
    while (!(done || error) && n < 1000) begin
      tick();
      n++;
    end
    check({nm, "_end_seen"}, 32'(done || error), 32'd1);
    check({nm, "_done_err"}, {30'd0, done, error}, {30'd0, ed, ~ed});
    check({nm, "_err_code"}, 32'(err_code), 32'(ec));
    check({nm, "_busy_end"}, 32'(busy), 32'd0);
    check({nm, "_leds_state"}, 32'(leds_state), 32'(els));
    tick();
    check({nm, "_pulse_len"}, {30'd0, done, error}, 32'd0);
    check({nm, "_code_held"}, 32'(err_code), 32'(ec));
  endtask

  task automatic run_txn(input txn_t t, input string nm);
    logic [7:0] cb;
    int f, h;
    cb = t.is_reset ? 8'hFF : 8'hED;
    pulse(t.is_reset, ~t.is_reset, t.leds);
    check({nm, "_busy"}, 32'(busy), 32'd1);
    check({nm, "_errclr"}, 32'(err_code), 32'd0);
    for (int a = 0; a <= t.k_cmd && a <= int'(MR); a++) begin
      expect_tx(cb, {nm, "_cmd"}, f, h);
      reply((a < t.k_cmd) ? 8'hFE : 8'hFA);
    end
    if (t.k_cmd <= int'(MR)) begin
      if (t.is_reset) begin
        if (t.bat == 0) reply(8'hAA);
        else if (t.bat == 1) reply(8'hFC);
      end else begin
        for (int a = 0; a <= t.k_arg && a <= int'(MR); a++) begin
          expect_tx({5'b00000, t.leds}, {nm, "_arg"}, f, h);
          reply((a < t.k_arg) ? 8'hFE : 8'hFA);
        end
      end
    end
    wait_result(t.exp_done, t.exp_code, t.exp_ls, nm);
  endtask

  // Transaction-level model: outcome from resend counts and BAT behaviour.
  function automatic txn_t predict(input txn_t t, input logic [2:0] ls_before);
    txn_t r;
    r = t;
    r.exp_done = 1'b0;
    r.exp_ls   = ls_before;
    if (t.k_cmd > int'(MR)) begin
      r.exp_code = 2'b01;
    end else if (t.is_reset) begin
      case (t.bat)
        0:       begin r.exp_done = 1'b1; r.exp_code = 2'b00; r.exp_ls = 3'b000; end
        1:       r.exp_code = 2'b10;
        default: r.exp_code = 2'b11;
      endcase
    end else if (t.k_arg > int'(MR)) begin
      r.exp_code = 2'b01;
    end else begin
      r.exp_done = 1'b1;
      r.exp_code = 2'b00;
      r.exp_ls   = t.leds;
    end
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int f, h, hprev, n, seen;
    logic [2:0] model_ls;
    txn_t t;

    table_v[0]  = '{1'b0, 3'b101, 0, 0, 0, 1'b1, 2'b00, 3'b101};
    table_v[1]  = '{1'b1, 3'b000, 0, 0, 0, 1'b1, 2'b00, 3'b000};
    table_v[2]  = '{1'b0, 3'b011, 3, 0, 0, 1'b1, 2'b00, 3'b011};
    table_v[3]  = '{1'b0, 3'b110, 1, 2, 0, 1'b1, 2'b00, 3'b110};
    table_v[4]  = '{1'b1, 3'b000, 0, 0, 1, 1'b0, 2'b10, 3'b110};
    table_v[5]  = '{1'b0, 3'b001, 0, 0, 0, 1'b1, 2'b00, 3'b001};
    table_v[6]  = '{1'b0, 3'b111, 4, 0, 0, 1'b0, 2'b01, 3'b001};
    table_v[7]  = '{1'b0, 3'b100, 0, 4, 0, 1'b0, 2'b01, 3'b001};
    table_v[8]  = '{1'b1, 3'b000, 0, 0, 2, 1'b0, 2'b11, 3'b001};
    table_v[9]  = '{1'b1, 3'b000, 4, 0, 0, 1'b0, 2'b01, 3'b001};
    table_v[10] = '{1'b0, 3'b010, 0, 0, 0, 1'b1, 2'b00, 3'b010};

    reset = 1'b0;
    req_reset = 1'b0;
    req_leds = 1'b0;
    leds = 3'b000;
    ps2.tx_ready = 1'b0;
    ps2.rx_ready = 1'b0;
    ps2.rx_data = 8'h00;
    repeat (3) tick();
    check("reset_outputs",
          {15'd0, ps2.tx_data, ps2.tx_valid, busy, done, error, err_code, leds_state},
          32'd0);
    reset = 1'b1;
    seen = 0;
    repeat (5) begin
      tick();
      if (ps2.tx_valid || busy) seen++;
    end
    check("idle_after_reset", 32'(seen), 32'd0);

    foreach (table_v[i]) run_txn(table_v[i], $sformatf("table%0d", i));

    // No reply at all: four ED transmissions spaced by the timeout, then error.
    pulse(1'b0, 1'b1, 3'b011);
    expect_tx(8'hED, "tmo0", f, hprev);
    for (int i = 1; i <= int'(MR); i++) begin
      expect_tx(8'hED, $sformatf("tmo%0d", i), f, h);
      check($sformatf("tmo%0d_gap", i), 32'(f - (hprev + 1)), 32'(TO));
      hprev = h;
    end
    n = 0;
    while (!error && n < 500) begin
      tick();
      n++;
    end
    check("tmo_err_gap", 32'(cyc - (hprev + 1)), 32'(TO));
    wait_result(1'b0, 2'b01, 3'b010, "tmo_end");

    // Requests while busy: LED requests collapse to the last, reset ignored.
    pulse(1'b0, 1'b1, 3'b101);
    expect_tx(8'hED, "pend_a_cmd", f, h);
    pulse(1'b0, 1'b1, 3'b001);
    pulse(1'b1, 1'b0, 3'b000);
    pulse(1'b0, 1'b1, 3'b011);
    reply(8'hFA);
    expect_tx(8'h05, "pend_a_arg", f, h);
    reply(8'hFA);
    wait_result(1'b1, 2'b00, 3'b101, "pend_a");
    expect_tx(8'hED, "pend_b_cmd", f, h);
    reply(8'hFA);
    expect_tx(8'h03, "pend_b_arg", f, h);
    reply(8'hFA);
    wait_result(1'b1, 2'b00, 3'b011, "pend_b");
    seen = 0;
    repeat (20) begin
      tick();
      if (ps2.tx_valid || busy) seen++;
    end
    check("pend_no_extra", 32'(seen), 32'd0);

    // Simultaneous requests: reset first, then the parked LED update.
    pulse(1'b1, 1'b1, 3'b010);
    expect_tx(8'hFF, "sim_rst", f, h);
    reply(8'hFA);
    reply(8'hAA);
    wait_result(1'b1, 2'b00, 3'b000, "sim_rst");
    expect_tx(8'hED, "sim_leds_cmd", f, h);
    reply(8'hFA);
    expect_tx(8'h02, "sim_leds_arg", f, h);
    reply(8'hFA);
    wait_result(1'b1, 2'b00, 3'b010, "sim_leds");

    // Random transactions against the model.
    model_ls = 3'b010;
    for (int i = 0; i < 40; i++) begin
      int r;
      t.is_reset = ($urandom_range(0, 3) == 0);
      t.leds     = 3'($urandom);
      r = $urandom_range(0, 9);
      t.k_cmd = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, 3) : 4;
      r = $urandom_range(0, 9);
      t.k_arg = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, 3) : 4;
      t.bat   = $urandom_range(0, 2);
      t = predict(t, model_ls);
      model_ls = t.exp_ls;
      run_txn(t, $sformatf("rnd%0d", i));
    end

    // Reset mid-sequence with a parked request: everything is dropped.
    pulse(1'b0, 1'b1, 3'b111);
    expect_tx(8'hED, "mid_cmd", f, h);
    pulse(1'b0, 1'b1, 3'b100);
    reply(8'hFE);
    check("mid_resend_valid", 32'(ps2.tx_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_reset_drop", {29'd0, ps2.tx_valid, busy, 1'b0}, 32'd0);
    check("mid_reset_leds", 32'(leds_state), 32'd0);
    tick();
    reset = 1'b1;
    seen = 0;
    repeat (30) begin
      tick();
      if (ps2.tx_valid || busy) seen++;
    end
    check("mid_pending_lost", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
